ts_packet_sync: RTL and testbench

Per-stream MPEG-2 TS packet synchronizer placed directly downstream of the TS byte source. It consumes one byte stream with a valid strobe, hunts for the 0x47 sync byte, and confirms packet alignment over consecutive 188-byte periods. Once locked it forwards bytes with start/end-of-packet markers to the QoS stages, flywheels through isolated sync errors, and reports lock status and error counts. One instance is used per input stream; four in the top level.

---
 rtl/ts_pkg.sv | 18 +
 rtl/ts_packet_sync_sat_counter.sv | 23 ++
 rtl/ts_packet_sync.sv | 168 ++++++++++++++++
 tb/tb_ts_packet_sync.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/ts_pkg.sv
// Shared MPEG-2 TS constants and the sync FSM state type.
// Used by every stage of the TS ingest path.
package ts_pkg;

    localparam int         TS_PKT_LEN   = 188;
    localparam logic [7:0] TS_SYNC_BYTE = 8'h47;

    typedef enum logic [1:0] {
        HUNT,
        VERIFY,
        LOCKED
    } sync_state_t;

    function automatic int maxInt(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ts_packet_sync_sat_counter.sv
// Saturating event counter with synchronous clear.
// Once it reaches all-ones it holds there.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/ts_packet_sync.sv
// MPEG-2 TS packet synchronizer: hunts for the sync byte, confirms alignment
// over consecutive packets, then forwards bytes with sop/eop and flywheels.
module ts_packet_sync
    import ts_pkg::*;
#(
    parameter int                    DATA_WIDTH   = 8,
    parameter int                    PKT_LEN      = TS_PKT_LEN,
    parameter logic [DATA_WIDTH-1:0] SYNC_BYTE    = TS_SYNC_BYTE,
    parameter int                    LOCK_COUNT   = 3,
    parameter int                    UNLOCK_COUNT = 3,
    parameter int                    CNT_WIDTH    = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_sop,
    output logic                  out_eop,
    output logic                  locked,
    output logic                  sync_loss,
    output logic [CNT_WIDTH-1:0]  pkt_count,
    output logic [CNT_WIDTH-1:0]  sync_err_count
);

    localparam int PW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam int HW = $clog2(maxInt(LOCK_COUNT, UNLOCK_COUNT) + 1);

    localparam logic [PW-1:0] LAST_POS    = PW'(PKT_LEN - 1);
    localparam logic [HW-1:0] LOCK_LAST   = HW'(LOCK_COUNT - 1);
    localparam logic [HW-1:0] UNLOCK_LAST = HW'(UNLOCK_COUNT - 1);

    sync_state_t           state_q, state_d;
    logic [PW-1:0]         pos_q, pos_d;
    logic [HW-1:0]         hits_q, hits_d;
    logic [HW-1:0]         misses_q, misses_d;

    logic                  outValid_q, outSop_q, outEop_q, syncLoss_q;
    logic [DATA_WIDTH-1:0] outData_q;

    logic                  isSync, atStart;
    logic [PW-1:0]         posNext;
    logic                  fwd_d, sop_d, eop_d, loss_d, errInc;

    assign isSync  = (in_data == SYNC_BYTE);
    assign atStart = (pos_q == '0);
    assign posNext = (pos_q == LAST_POS) ? '0 : pos_q + 1'b1;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= HUNT;
            pos_q    <= '0;
            hits_q   <= '0;
            misses_q <= '0;
        end else begin
            state_q  <= state_d;
            pos_q    <= pos_d;
            hits_q   <= hits_d;
            misses_q <= misses_d;
        end
    end

    // The byte that fails a VERIFY check sends us back to HUNT without being
    // considered as a fresh sync candidate; hunting restarts on the next byte.
    always_comb begin
        state_d  = state_q;
        pos_d    = pos_q;
        hits_d   = hits_q;
        misses_d = misses_q;
        if (in_valid) begin
            case (state_q)
                HUNT: begin
                    if (isSync) begin
                        pos_d   = PW'(1);
                        hits_d  = HW'(1);
                        state_d = (LOCK_COUNT == 1) ? LOCKED : VERIFY;
                    end
                end
                VERIFY: begin
                    pos_d = posNext;
                    if (atStart) begin
                        if (isSync) begin
                            hits_d = hits_q + 1'b1;
                            if (hits_q == LOCK_LAST) begin
                                state_d = LOCKED;
                            end
                        end else begin
                            state_d = HUNT;
                            hits_d  = '0;
                            pos_d   = '0;
                        end
                    end
                end
                LOCKED: begin
                    pos_d = posNext;
                    if (atStart) begin
                        if (isSync) begin
                            misses_d = '0;
                        end else if (misses_q == UNLOCK_LAST) begin
                            state_d  = HUNT;
                            hits_d   = '0;
                            misses_d = '0;
                            pos_d    = '0;
                        end else begin
                            misses_d = misses_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = HUNT;
                end
            endcase
        end
    end

    // A byte is forwarded while locked, including the one that completes lock
    // and the one that drops it.
    always_comb begin
        fwd_d  = in_valid && ((state_q == LOCKED) || (state_d == LOCKED));
        sop_d  = fwd_d && ((state_q != LOCKED) || atStart);
        eop_d  = fwd_d && (state_q == LOCKED) && (pos_q == LAST_POS);
        loss_d = in_valid && (state_q == LOCKED) && (state_d == HUNT);
        errInc = in_valid && (state_q == LOCKED) && atStart && !isSync;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            outValid_q <= 1'b0;
            outSop_q   <= 1'b0;
            outEop_q   <= 1'b0;
            syncLoss_q <= 1'b0;
            outData_q  <= '0;
        end else begin
            outValid_q <= fwd_d;
            outSop_q   <= sop_d;
            outEop_q   <= eop_d;
            syncLoss_q <= loss_d;
            if (fwd_d) begin
                outData_q <= in_data;
            end
        end
    end

    sat_counter #(.WIDTH(CNT_WIDTH)) pktCounter (
        .clk   (clk),
        .rstn  (rstn),
        .clr   (1'b0),
        .inc   (sop_d),
        .count (pkt_count)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) errCounter (
        .clk   (clk),
        .rstn  (rstn),
        .clr   (1'b0),
        .inc   (errInc),
        .count (sync_err_count)
    );

    assign out_valid = outValid_q;
    assign out_data  = outData_q;
    assign out_sop   = outSop_q;
    assign out_eop   = outEop_q;
    assign sync_loss = syncLoss_q;
    assign locked    = (state_q == LOCKED);

endmodule

// File: tb/tb_ts_packet_sync.sv
// Directed self-checking bench for ts_packet_sync: clean, junk-prefixed,
// false-sync, corrupted, gapped and mid-packet-reset streams.
module tb_ts_packet_sync;

    localparam int NEVER = 1 << 30;

    logic        clk = 1'b0;
    logic        rstn;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_sop;
    logic        out_eop;
    logic        locked;
    logic        sync_loss;
    logic [15:0] pkt_count;
    logic [15:0] sync_err_count;

    int          checks = 0;
    int          failures = 0;
    int          corruptList[$];
    logic [7:0]  lastData;

    always #5 clk = ~clk;

    ts_packet_sync dut (
        .clk            (clk),
        .rstn           (rstn),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .out_valid      (out_valid),
        .out_data       (out_data),
        .out_sop        (out_sop),
        .out_eop        (out_eop),
        .locked         (locked),
        .sync_loss      (sync_loss),
        .pkt_count      (pkt_count),
        .sync_err_count (sync_err_count)
    );

    // Stream byte at absolute offset k: sync every 188 bytes from start,
    // payload bytes that can never be 0x47, plus injected errors.
    function automatic logic [7:0] byteAt(input int k, input int start, input int falseAt);
        foreach (corruptList[i]) begin
            if (corruptList[i] == k) return 8'h00;
        end
        if (k == falseAt) return 8'h47;
        if ((k >= start) && (((k - start) % 188) == 0)) return 8'h47;
        return 8'((k % 61) + 128);
    endfunction

    task automatic checkOutput(input string tag, input int k, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s at %0d: observed=%0h expected=%0h", tag, k, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput(tag, 0,
                    {19'd0, out_valid, out_sop, out_eop, locked, sync_loss,
                     out_data, pkt_count, sync_err_count},
                    64'd0);
    endtask

    task automatic applyReset();
        in_valid = 1'b0;
        rstn     = 1'b0;
        #12;
        checkAllZero("reset");
        lastData = 8'h00;
        @(negedge clk);
        rstn = 1'b1;
    endtask

    // Sends offsets base..base+n-1; forwarding expected from lockAt through lossAt.
    task automatic runSegment(input int base, input int n, input int start, input int falseAt,
                              input int lockAt, input int lossAt, input int gap);
        for (int k = base; k < base + n; k++) begin
            logic [7:0] b;
            logic       fwd, sop, eop;
            b = byteAt(k, start, falseAt);
            applyStimulus(b);
            fwd = (k >= lockAt) && (k <= lossAt);
            sop = fwd && (((k - lockAt) % 188) == 0);
            eop = fwd && (((k - lockAt) % 188) == 187);
            checkOutput("flags", k,
                        {59'd0, out_valid, out_sop, out_eop, locked, sync_loss},
                        {59'd0, fwd, sop, eop, fwd && (k != lossAt), k == lossAt});
            if (fwd) begin
                lastData = b;
                checkOutput("data", k, {56'd0, out_data}, {56'd0, b});
            end
            for (int g = 0; g < gap; g++) begin
                @(posedge clk);
                #1;
                checkOutput("idle", k, {60'd0, out_valid, out_sop, out_eop, sync_loss}, 64'd0);
                checkOutput("hold", k, {56'd0, out_data}, {56'd0, lastData});
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rstn     = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        lastData = 8'h00;

        // Clean stream: lock on the third sync at 376.
        applyReset();
        runSegment(0, 940, 0, -1, 376, NEVER, 0);
        checkOutput("cleanPkts", 940, {48'd0, pkt_count}, 64'd3);
        checkOutput("cleanErrs", 940, {48'd0, sync_err_count}, 64'd0);

        // Two missed syncs, one clean, then three missed: loss on the third.
        corruptList = '{940, 1128, 1504, 1692, 1880};
        runSegment(940, 400, 0, -1, 376, NEVER, 0);
        checkOutput("flyErrs", 1340, {48'd0, sync_err_count}, 64'd2);
        checkOutput("flyPkts", 1340, {48'd0, pkt_count}, 64'd6);
        checkOutput("flyLocked", 1340, {63'd0, locked}, 64'd1);
        runSegment(1340, 560, 0, -1, 376, 1880, 0);
        checkOutput("lossErrs", 1900, {48'd0, sync_err_count}, 64'd5);
        checkOutput("lossPkts", 1900, {48'd0, pkt_count}, 64'd9);
        checkOutput("lossLocked", 1900, {63'd0, locked}, 64'd0);
        corruptList.delete();

        // Junk preamble of 50 bytes.
        applyReset();
        runSegment(0, 990, 50, -1, 426, NEVER, 0);
        checkOutput("junkPkts", 990, {48'd0, pkt_count}, 64'd3);

        // False sync at 10, real stream at 100: lock at 664.
        applyReset();
        runSegment(0, 1040, 100, 10, 664, NEVER, 0);
        checkOutput("falsePkts", 1040, {48'd0, pkt_count}, 64'd2);
        checkOutput("falseErrs", 1040, {48'd0, sync_err_count}, 64'd0);

        // One valid byte every three cycles.
        applyReset();
        runSegment(0, 600, 0, -1, 376, NEVER, 2);
        checkOutput("gapPkts", 600, {48'd0, pkt_count}, 64'd2);
        checkOutput("gapLocked", 600, {63'd0, locked}, 64'd1);

        // Asynchronous reset mid-packet, then relock three syncs later.
        #2;
        rstn = 1'b0;
        #1;
        checkAllZero("asyncReset");
        lastData = 8'h00;
        @(negedge clk);
        rstn = 1'b1;
        runSegment(600, 700, 0, -1, 1128, NEVER, 0);
        checkOutput("relockPkts", 1300, {48'd0, pkt_count}, 64'd1);
        checkOutput("relockLocked", 1300, {63'd0, locked}, 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
